// File: rtl/inst_fetch_unit_pkg.sv
// Shared bus-side types for the Harvard system.
package XT_BUS;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: drives the 1-cycle-latency instruction RAM and presents a
// valid/ready beat stream to decode, with redirects, boot hold and a misalignment fault.
module inst_fetch_unit
    import XT_BUS::*;
#(
    parameter int          INST_RAM_DEPTH = 512,
    parameter logic [31:0] RESET_PC       = 32'h0,
    localparam int         AW             = $clog2(INST_RAM_DEPTH * 4)
) (
    input  logic          hb_clk,
    input  logic          hb_rst,
    input  logic          boot_hold,
    output logic          ram_inst_clk_en,
    output logic [AW-1:0] ram_instruction_r_addr,
    input  logic [31:0]   ram_instruction_r_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_valid,
    input  logic          id_ready,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_inst,
    output logic          fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         resp_valid_q, resp_valid_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic         fault_q, fault_d;
    logic [31:0]  issue_pc;
    logic         issue;
    logic         out_free;
    logic         load;

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        resp_valid_d    = resp_valid_q;
        resp_pc_d       = resp_pc_q;
        if_valid_d      = if_valid_q;
        if_pc_d         = if_pc_q;
        if_inst_d       = if_inst_q;
        fault_d         = fault_q;
        issue           = 1'b0;
        issue_pc        = fetch_pc_q;
        ram_inst_clk_en = 1'b0;
        out_free        = !if_valid_q || id_ready;
        load            = 1'b0;

        case (state_q)
            BOOT: begin
                ram_inst_clk_en = 1'b1;
                if (!boot_hold) begin
                    state_d    = RUN;
                    fetch_pc_d = RESET_PC;
                end
            end
            RUN: begin
                if (boot_hold) begin
                    // RAM stays enabled so the boot loader can write from this cycle on
                    state_d         = BOOT;
                    ram_inst_clk_en = 1'b1;
                    resp_valid_d    = 1'b0;
                    if_valid_d      = 1'b0;
                    fetch_pc_d      = RESET_PC;
                end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d      = HALT;
                    fault_d      = 1'b1;
                    resp_valid_d = 1'b0;
                    if_valid_d   = 1'b0;
                end else begin
                    if (redirect_valid) begin
                        issue        = 1'b1;
                        issue_pc     = redirect_pc;
                        resp_valid_d = 1'b0;
                        if_valid_d   = 1'b0;
                    end else begin
                        issue = !resp_valid_q || out_free;
                        load  = resp_valid_q && out_free;
                        if (load) begin
                            if_valid_d   = 1'b1;
                            if_pc_d      = resp_pc_q;
                            if_inst_d    = ram_instruction_r_data;
                            resp_valid_d = 1'b0;
                        end else if (id_ready) begin
                            if_valid_d = 1'b0;
                        end
                    end
                    // A stalled full pipe keeps clk_en low so RAM Q holds the pending word
                    if (issue) begin
                        ram_inst_clk_en = 1'b1;
                        resp_valid_d    = 1'b1;
                        resp_pc_d       = issue_pc;
                        fetch_pc_d      = issue_pc + 32'd4;
                    end
                end
            end
            HALT: begin
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            state_q      <= BOOT;
            fetch_pc_q   <= RESET_PC;
            resp_valid_q <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_inst_q    <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            fault_q      <= fault_d;
        end
    end

    always_ff @(posedge hb_clk) begin
        resp_pc_q <= resp_pc_d;
    end

    assign ram_instruction_r_addr = issue_pc[AW-1:0];
    assign if_valid               = if_valid_q;
    assign if_pc                  = if_pc_q;
    assign if_inst                = if_inst_q;
    assign fetch_fault            = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle-latency RAM model and a beat scoreboard.
module tb_inst_fetch_unit;

    localparam int AW = 11;

    logic          hb_clk = 1'b0;
    logic          hb_rst;
    logic          boot_hold;
    logic          ram_inst_clk_en;
    logic [AW-1:0] ram_instruction_r_addr;
    logic [31:0]   ram_instruction_r_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          if_valid;
    logic          id_ready;
    logic [31:0]   if_pc;
    logic [31:0]   if_inst;
    logic          fetch_fault;

    inst_fetch_unit #(.INST_RAM_DEPTH(512), .RESET_PC(32'h0)) dut (
        .hb_clk                 (hb_clk),
        .hb_rst                 (hb_rst),
        .boot_hold              (boot_hold),
        .ram_inst_clk_en        (ram_inst_clk_en),
        .ram_instruction_r_addr (ram_instruction_r_addr),
        .ram_instruction_r_data (ram_instruction_r_data),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .if_valid               (if_valid),
        .id_ready               (id_ready),
        .if_pc                  (if_pc),
        .if_inst                (if_inst),
        .fetch_fault            (fetch_fault)
    );

    always #5 hb_clk = ~hb_clk;

    logic [31:0] mem [512];
    always @(posedge hb_clk) begin
        if (ram_inst_clk_en) ram_instruction_r_data <= mem[ram_instruction_r_addr[AW-1:2]];
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    patched  = 1'b0;

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [8:0] w;
        w = pc[10:2];
        if (patched && w == 9'd0) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + {23'd0, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        beat_t b;
        b.pc   = pc;
        b.inst = exp_inst(pc);
        exp_q.push_back(b);
    endtask

    // One clock; any beat handshaken at this edge is checked against the scoreboard.
    task automatic tick();
        logic        hs;
        logic [31:0] p;
        logic [31:0] d;
        beat_t       e;
        hs = if_valid && id_ready;
        p  = if_pc;
        d  = if_inst;
        @(posedge hb_clk);
        #1;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("beat_extra_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_pc", {32'h0, p}, {32'h0, e.pc});
                chk("beat_inst", {32'h0, d}, {32'h0, e.inst});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
        hb_rst         = 1'b1;
        boot_hold      = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        tick();
        tick();
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", 64'(if_pc), 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_clk_en", 64'(ram_inst_clk_en), 64'd1);

        // Release reset: cycle 0 is the boot release, first beat at cycle 3
        hb_rst = 1'b0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        tick();
        tick();
        chk("boot_lat_c2", 64'(if_valid), 64'd0);
        tick();
        chk("boot_lat_c3", 64'(if_valid), 64'd1);
        chk("boot_first_pc", 64'(if_pc), 64'd0);
        tick();
        tick();

        // Stall for 5 cycles with pc 8 presented
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_clk_en", 64'(ram_inst_clk_en), 64'd0);
            chk("stall_pc", 64'(if_pc), 64'h8);
            chk("stall_inst", 64'(if_inst), 64'h1000_0002);
            tick();
        end
        id_ready = 1'b1;
        tick();
        tick();
        chk("resume_q_empty", 64'(exp_q.size()), 64'd0);

        // Fill both stages, then redirect while stalled
        id_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("redir_clk_en", 64'(ram_inst_clk_en), 64'd1);
        chk("redir_addr", 64'(ram_instruction_r_addr), 64'h40);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        chk("redir_r1_valid", 64'(if_valid), 64'd0);
        push(32'h40); push(32'h44); push(32'h48); push(32'h4C);
        tick();
        chk("redir_r2_valid", 64'(if_valid), 64'd1);
        chk("redir_r2_pc", 64'(if_pc), 64'h40);
        tick();
        tick();
        tick();

        // Redirect near the top of RAM; beat 0x4C is delivered in the redirect cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7F8;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_r1_valid", 64'(if_valid), 64'd0);
        chk("redir_hs_q_empty", 64'(exp_q.size()), 64'd0);
        push(32'h7F8); push(32'h7FC); push(32'h800);
        tick();
        chk("wrap_addr", 64'(ram_instruction_r_addr), 64'h0);
        chk("wrap_clk_en", 64'(ram_inst_clk_en), 64'd1);
        tick();
        tick();
        tick();
        chk("wrap_q_empty", 64'(exp_q.size()), 64'd0);

        // Boot hold for 10 cycles with a RAM write of word 0
        id_ready  = 1'b0;
        boot_hold = 1'b1;
        #1;
        chk("hold_c0_clk_en", 64'(ram_inst_clk_en), 64'd1);
        tick();
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                mem[0]  = 32'hDEAD_BEEF;
                patched = 1'b1;
            end
            chk("hold_if_valid", 64'(if_valid), 64'd0);
            chk("hold_clk_en", 64'(ram_inst_clk_en), 64'd1);
            tick();
        end
        boot_hold = 1'b0;
        id_ready  = 1'b1;
        push(32'h0); push(32'h4);
        tick();
        tick();
        chk("rel_lat_n2", 64'(if_valid), 64'd0);
        tick();
        chk("rel_lat_n3", 64'(if_valid), 64'd1);
        chk("rel_first_inst", 64'(if_inst), 64'hDEAD_BEEF);
        tick();
        tick();
        chk("rel_q_empty", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect halts fetch until reset
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        #1;
        chk("mis_clk_en", 64'(ram_inst_clk_en), 64'd0);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = (i == 1);
            redirect_pc    = 32'h40;
            #1;
            chk("halt_fault", 64'(fetch_fault), 64'd1);
            chk("halt_if_valid", 64'(if_valid), 64'd0);
            chk("halt_clk_en", 64'(ram_inst_clk_en), 64'd0);
            tick();
        end
        redirect_valid = 1'b0;
        hb_rst         = 1'b1;
        tick();
        chk("rerst_fault", 64'(fetch_fault), 64'd0);
        chk("rerst_clk_en", 64'(ram_inst_clk_en), 64'd1);
        chk("rerst_if_valid", 64'(if_valid), 64'd0);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
